// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the 640x480@60 display pipeline.
// The sprite modules also import COORD_W and the flag struct from here.
package vga_timing_pkg;

   localparam int COORD_W = 10;
   localparam int DIV_W   = 4;

   localparam int CLK_DIV_DEF  = 2;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam bit SYNC_POL_DEF = 1'b0;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

   localparam logic [COORD_W-1:0] COORD_ZERO = 10'd0;
   localparam logic [COORD_W-1:0] COORD_ONE  = 10'd1;
   localparam logic [DIV_W-1:0]   DIV_ZERO   = 4'd0;
   localparam logic [DIV_W-1:0]   DIV_ONE    = 4'd1;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
      logic pixel_tick;
      logic line_start;
      logic frame_start;
   } vid_flags_t;

   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position and sync bundle: the timing generator drives it (master),
// sprite renderers and the compositor observe it (slave).
interface vga_timing_gen_if;

   logic [vga_timing_pkg::COORD_W-1:0] x;
   logic [vga_timing_pkg::COORD_W-1:0] y;
   logic                               hsync;
   logic                               vsync;
   logic                               active;
   logic                               pixel_tick;
   logic                               line_start;
   logic                               frame_start;

   modport master (output x, y, hsync, vsync, active, pixel_tick, line_start, frame_start);
   modport slave  (input  x, y, hsync, vsync, active, pixel_tick, line_start, frame_start);

endinterface

// File: rtl/vga_timing_gen_pixel_clk_div.sv
// Board-clock to pixel-rate divider; tick marks the edge on which the
// raster advances (every CLK_DIV-th edge, every edge when CLK_DIV=1).
module pixel_clk_div
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_div_range_err
      $error("pixel_clk_div: CLK_DIV must be in 1..16");
   end

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_r;

   assign tick = (div_cnt_r == DIV_LAST);

   // divider counter, wraps on the advance edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_r <= DIV_ZERO;
      end else if (tick) begin
         div_cnt_r <= DIV_ZERO;
      end else begin
         div_cnt_r <= div_cnt_r + DIV_ONE;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan timing generator: x/y counters plus hsync, vsync, active and
// pixel/line/frame strobes, all registered from the next-state position.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = SYNC_POL_DEF
) (
   input  logic             clk,
   input  logic             reset,
   vga_timing_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024) begin : g_h_total_err
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_v_total_err
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end

   localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT_L = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT_L = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_LO   = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_HI   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_LO   = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_HI   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = !SYNC_POL;

   localparam vid_flags_t FLAGS_RST = '{hsync: SYNC_OFF, vsync: SYNC_OFF, active: 1'b0,
                                        pixel_tick: 1'b0, line_start: 1'b0, frame_start: 1'b0};

   logic               adv_s;
   logic [COORD_W-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
   vid_flags_t         flags_r, flags_nxt_s;

   pixel_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk  (clk),
      .reset(reset),
      .tick (adv_s)
   );

   // next raster position; y only moves when x wraps
   always_comb begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
      if (adv_s) begin
         if (x_r == H_LAST) begin
            x_nxt_s = COORD_ZERO;
            if (y_r == V_LAST) begin
               y_nxt_s = COORD_ZERO;
            end else begin
               y_nxt_s = y_r + COORD_ONE;
            end
         end else begin
            x_nxt_s = x_r + COORD_ONE;
         end
      end else begin
         x_nxt_s = x_r;
      end
   end

   // decode flags from the next position so they align with x/y
   always_comb begin
      flags_nxt_s             = FLAGS_RST;
      flags_nxt_s.hsync       = in_window(x_nxt_s, HS_LO, HS_HI) ? SYNC_ON : SYNC_OFF;
      flags_nxt_s.vsync       = in_window(y_nxt_s, VS_LO, VS_HI) ? SYNC_ON : SYNC_OFF;
      flags_nxt_s.active      = (x_nxt_s < H_ACT_L) && (y_nxt_s < V_ACT_L);
      flags_nxt_s.pixel_tick  = adv_s;
      flags_nxt_s.line_start  = adv_s && (x_nxt_s == COORD_ZERO);
      flags_nxt_s.frame_start = adv_s && (x_nxt_s == COORD_ZERO) && (y_nxt_s == COORD_ZERO);
   end

   // position and flag registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_r     <= H_LAST;
         y_r     <= V_LAST;
         flags_r <= FLAGS_RST;
      end else begin
         x_r     <= x_nxt_s;
         y_r     <= y_nxt_s;
         flags_r <= flags_nxt_s;
      end
   end

   assign vid.x           = x_r;
   assign vid.y           = y_r;
   assign vid.hsync       = flags_r.hsync;
   assign vid.vsync       = flags_r.vsync;
   assign vid.active      = flags_r.active;
   assign vid.pixel_tick  = flags_r.pixel_tick;
   assign vid.line_start  = flags_r.line_start;
   assign vid.frame_start = flags_r.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level and reset checks,
// two shrunken geometries (15x10) for whole-frame, CLK_DIV=1 and SYNC_POL=1.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic ra, rb, rc;
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   hold_err = 0;

   always #5 clk = ~clk;

   vga_timing_gen_if ifa();
   vga_timing_gen_if ifb();
   vga_timing_gen_if ifc();

   vga_timing_gen u_a (.clk(clk), .reset(ra), .vid(ifa));

   vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0))
      u_b (.clk(clk), .reset(rb), .vid(ifb));

   vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1))
      u_c (.clk(clk), .reset(rc), .vid(ifc));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // step instance A to its next advance edge, watching x hold in between
   task automatic adv_a();
      logic [9:0] x0;
      x0 = ifa.x;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ifa.pixel_tick === 1'b1) return;
         if (ifa.x !== x0) hold_err++;
      end
      check_eq("adv_a_timeout", ifa.pixel_tick, 1);
   endtask

   task automatic restart_a(input string tag);
      @(negedge clk); ra = 1'b1;
      @(posedge clk); #1;
      check_eq({tag, "_e1_x"}, ifa.x, 799);
      check_eq({tag, "_e1_pt"}, ifa.pixel_tick, 0);
      @(posedge clk); #1;
      check_eq({tag, "_e2_x"}, ifa.x, 0);
      check_eq({tag, "_e2_y"}, ifa.y, 0);
      check_eq({tag, "_e2_act"}, ifa.active, 1);
      check_eq({tag, "_e2_fs"}, ifa.frame_start, 1);
      check_eq({tag, "_e2_ls"}, ifa.line_start, 1);
      check_eq({tag, "_e2_pt"}, ifa.pixel_tick, 1);
      @(posedge clk); #1;
      check_eq({tag, "_e3_x"}, ifa.x, 0);
      check_eq({tag, "_e3_pt"}, ifa.pixel_tick, 0);
      check_eq({tag, "_e3_ls"}, ifa.line_start, 0);
      check_eq({tag, "_e3_fs"}, ifa.frame_start, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int inc_err, found, period, act, hs_cnt, vs_lines, vbad, vchg, pt_low;
      logic prev_vs, exp_s;

      ra = 1'b0; rb = 1'b0; rc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_a_x", ifa.x, 799);
      check_eq("rst_a_y", ifa.y, 524);
      check_eq("rst_a_hs", ifa.hsync, 1);
      check_eq("rst_a_vs", ifa.vsync, 1);
      check_eq("rst_a_act", ifa.active, 0);
      check_eq("rst_a_strobes", {ifa.pixel_tick, ifa.line_start, ifa.frame_start}, 0);
      check_eq("rst_c_x", ifc.x, 14);
      check_eq("rst_c_y", ifc.y, 9);
      check_eq("rst_c_hs", ifc.hsync, 0);
      check_eq("rst_c_vs", ifc.vsync, 0);

      restart_a("s1");

      // one full default line
      inc_err = 0;
      for (int i = 1; i < 800; i++) begin
         adv_a();
         if (ifa.x !== 10'(i)) inc_err++;
         case (i)
            639:     check_eq("s2_act_639", ifa.active, 1);
            640:     check_eq("s2_act_640", ifa.active, 0);
            655:     check_eq("s2_hs_655", ifa.hsync, 1);
            656:     check_eq("s2_hs_656", ifa.hsync, 0);
            751:     check_eq("s2_hs_751", ifa.hsync, 0);
            752:     check_eq("s2_hs_752", ifa.hsync, 1);
            799:     check_eq("s2_y_799", ifa.y, 0);
            default: ;
         endcase
      end
      check_eq("s2_x_seq", inc_err, 0);
      adv_a();
      check_eq("s2_wrap_x", ifa.x, 0);
      check_eq("s2_wrap_y", ifa.y, 1);
      check_eq("s2_wrap_ls", ifa.line_start, 1);
      check_eq("s2_wrap_fs", ifa.frame_start, 0);
      check_eq("s2_wrap_act", ifa.active, 1);

      // asynchronous reset mid-line
      for (int i = 0; i < 300; i++) adv_a();
      check_eq("s5_pre_x", ifa.x, 300);
      #2; ra = 1'b0; #1;
      check_eq("s5_async_x", ifa.x, 799);
      check_eq("s5_async_y", ifa.y, 524);
      check_eq("s5_async_act", ifa.active, 0);
      check_eq("s5_async_hs", ifa.hsync, 1);
      check_eq("s5_async_pt", ifa.pixel_tick, 0);
      repeat (2) @(posedge clk);
      restart_a("s5");
      check_eq("a_hold_between_adv", hold_err, 0);

      // whole frame on small geometry, CLK_DIV=3
      @(negedge clk); rb = 1'b1;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(posedge clk); #1;
         if (ifb.frame_start === 1'b1) found = 1;
      end
      check_eq("s3_first_fs", found, 1);
      period   = 0;
      act      = (ifb.pixel_tick && ifb.active) ? 1 : 0;
      hs_cnt   = (ifb.pixel_tick && !ifb.hsync) ? 1 : 0;
      vs_lines = 0; vbad = 0; vchg = 0;
      prev_vs  = ifb.vsync;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         period++;
         if (ifb.frame_start === 1'b1) break;
         if (ifb.pixel_tick && ifb.active) act++;
         if (ifb.pixel_tick && !ifb.hsync) hs_cnt++;
         if (ifb.line_start && !ifb.vsync) vs_lines++;
         exp_s = (ifb.y >= 10'd7 && ifb.y <= 10'd8) ? 1'b0 : 1'b1;
         if (ifb.vsync !== exp_s) vbad++;
         if (ifb.vsync !== prev_vs && ifb.line_start !== 1'b1) vchg++;
         prev_vs = ifb.vsync;
      end
      check_eq("s3_period", period, 450);
      check_eq("s3_active_cnt", act, 48);
      check_eq("s3_hsync_cnt", hs_cnt, 30);
      check_eq("s3_vsync_lines", vs_lines, 2);
      check_eq("s3_vsync_window", vbad, 0);
      check_eq("s3_vsync_off_wrap", vchg, 0);

      // CLK_DIV=1, SYNC_POL=1
      @(negedge clk); rc = 1'b1;
      @(posedge clk); #1;
      check_eq("s4_x0", ifc.x, 0);
      check_eq("s4_y0", ifc.y, 0);
      check_eq("s4_fs", ifc.frame_start, 1);
      check_eq("s4_pt", ifc.pixel_tick, 1);
      period = 0; pt_low = 0; hs_cnt = 0; vs_lines = 0; vbad = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         period++;
         if (ifc.pixel_tick !== 1'b1) pt_low++;
         if (ifc.frame_start === 1'b1) break;
         exp_s = (ifc.x >= 10'd10 && ifc.x <= 10'd12) ? 1'b1 : 1'b0;
         if (ifc.hsync !== exp_s) vbad++;
         if (ifc.hsync) hs_cnt++;
         if (ifc.line_start && ifc.vsync) vs_lines++;
      end
      check_eq("s4_period", period, 150);
      check_eq("s4_pt_low", pt_low, 0);
      check_eq("s6_hsync_cnt", hs_cnt, 30);
      check_eq("s6_hsync_window", vbad, 0);
      check_eq("s6_vsync_lines", vs_lines, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
